// File: rtl/asrv32_encoder_if.sv
// rtl/asrv32_encoder_if.sv - request/output bus bundle for the RV32I encoder
interface asrv32_encoder_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [3:0]  i_kind;
  logic [2:0]  i_funct3;
  logic        i_alt;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [4:0]  i_rd;
  logic [31:0] i_imm;
  logic [31:0] o_inst;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic        o_err_valid;
  logic [1:0]  o_err_code;

  modport master (
    output i_req_valid, i_kind, i_funct3, i_alt, i_rs1, i_rs2, i_rd, i_imm, i_inst_ready,
    input  o_req_ready, o_inst, o_inst_valid, o_err_valid, o_err_code
  );

  modport slave (
    input  i_req_valid, i_kind, i_funct3, i_alt, i_rs1, i_rs2, i_rd, i_imm, i_inst_ready,
    output o_req_ready, o_inst, o_inst_valid, o_err_valid, o_err_code
  );
endinterface

// File: rtl/asrv32_encoder.sv
// rtl/asrv32_encoder.sv - RV32I instruction encoder with LI macro expansion
module asrv32_encoder (
  input logic              i_clk,
  input logic              i_rst_n,
  asrv32_encoder_if.slave  bus
);

  typedef enum logic {IDLE, PEND2} state_t;

  localparam logic [3:0] K_RTYPE  = 4'd0,  K_ITYPE = 4'd1,  K_LOAD  = 4'd2,  K_STORE = 4'd3;
  localparam logic [3:0] K_BRANCH = 4'd4,  K_JAL   = 4'd5,  K_JALR  = 4'd6,  K_LUI   = 4'd7;
  localparam logic [3:0] K_AUIPC  = 4'd8,  K_SYSTEM = 4'd9, K_FENCE = 4'd10, K_LI    = 4'd11;

  localparam logic [6:0] OP_OP     = 7'h33, OP_IMM   = 7'h13, OP_LOAD  = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_JAL   = 7'h6F, OP_JALR  = 7'h67, OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17, OP_SYSTEM = 7'h73, OP_FENCE = 7'h0F;

  localparam logic [1:0] E_KIND = 2'd0, E_RANGE = 2'd1, E_ALIGN = 2'd2, E_SHIFT = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pend_q, pend_d;
  logic        inst_valid_q, inst_valid_d;
  logic        err_valid_q, err_valid_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        enc_err, enc_two;
  logic [1:0]  enc_code;
  logic [31:0] enc_w0, enc_w1;

  logic [31:0] imm;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic        alt, fits12, fits13, fits21, is_shift;
  logic [19:0] li_hi;
  logic        out_free, req_ready, accept;

  assign imm = bus.i_imm;
  assign f3  = bus.i_funct3;
  assign alt = bus.i_alt;
  assign rs1 = bus.i_rs1;
  assign rs2 = bus.i_rs2;
  assign rd  = bus.i_rd;

  // A value fits N signed bits when every bit from N-1 upward equals the sign.
  assign fits12   = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13   = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21   = (&imm[31:20]) | ~(|imm[31:20]);
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  // Upper part rounded so that the sign-extended ADDI low part lands back on imm.
  assign li_hi    = imm[31:12] + {19'd0, imm[11]};

  assign out_free  = !inst_valid_q || bus.i_inst_ready;
  assign req_ready = i_rst_n && (state_q == IDLE) && out_free;
  assign accept    = bus.i_req_valid && req_ready;

  // Encode the current request, checking errors in kind/shift/alignment/range order.
  always_comb begin
    enc_err  = 1'b0;
    enc_code = E_KIND;
    enc_two  = 1'b0;
    enc_w0   = 32'd0;
    enc_w1   = 32'd0;
    case (bus.i_kind)
      K_RTYPE: begin
        if (alt && (f3 != 3'b000) && (f3 != 3'b101)) begin
          enc_err = 1'b1; enc_code = E_SHIFT;
        end else begin
          enc_w0 = {1'b0, alt, 5'd0, rs2, rs1, f3, rd, OP_OP};
        end
      end
      K_ITYPE: begin
        if (is_shift) begin
          if ((|imm[31:5]) || ((f3 == 3'b001) && alt)) begin
            enc_err = 1'b1; enc_code = E_SHIFT;
          end else begin
            enc_w0 = {1'b0, alt && (f3 == 3'b101), 5'd0, imm[4:0], rs1, f3, rd, OP_IMM};
          end
        end else if (!fits12) begin
          enc_err = 1'b1; enc_code = E_RANGE;
        end else begin
          enc_w0 = {imm[11:0], rs1, f3, rd, OP_IMM};
        end
      end
      K_LOAD, K_JALR: begin
        if (!fits12) begin
          enc_err = 1'b1; enc_code = E_RANGE;
        end else begin
          enc_w0 = {imm[11:0], rs1, f3, rd, (bus.i_kind == K_LOAD) ? OP_LOAD : OP_JALR};
        end
      end
      K_STORE: begin
        if (!fits12) begin
          enc_err = 1'b1; enc_code = E_RANGE;
        end else begin
          enc_w0 = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
        end
      end
      K_BRANCH: begin
        if (imm[0]) begin
          enc_err = 1'b1; enc_code = E_ALIGN;
        end else if (!fits13) begin
          enc_err = 1'b1; enc_code = E_RANGE;
        end else begin
          enc_w0 = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
        end
      end
      K_JAL: begin
        if (imm[0]) begin
          enc_err = 1'b1; enc_code = E_ALIGN;
        end else if (!fits21) begin
          enc_err = 1'b1; enc_code = E_RANGE;
        end else begin
          enc_w0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        end
      end
      K_LUI, K_AUIPC: begin
        if (|imm[11:0]) begin
          enc_err = 1'b1; enc_code = E_RANGE;
        end else begin
          enc_w0 = {imm[31:12], rd, (bus.i_kind == K_LUI) ? OP_LUI : OP_AUIPC};
        end
      end
      K_SYSTEM, K_FENCE: begin
        if (|imm[31:12]) begin
          enc_err = 1'b1; enc_code = E_RANGE;
        end else begin
          enc_w0 = {imm[11:0], rs1, f3, rd, (bus.i_kind == K_SYSTEM) ? OP_SYSTEM : OP_FENCE};
        end
      end
      K_LI: begin
        if (fits12) begin
          enc_w0 = {imm[11:0], 5'd0, 3'd0, rd, OP_IMM};
        end else if (~(|imm[11:0])) begin
          enc_w0 = {imm[31:12], rd, OP_LUI};
        end else begin
          enc_two = 1'b1;
          enc_w0  = {li_hi, rd, OP_LUI};
          enc_w1  = {imm[11:0], rd, 3'd0, rd, OP_IMM};
        end
      end
      default: begin
        enc_err = 1'b1; enc_code = E_KIND;
      end
    endcase
  end

  // Next-state: load the output register on acceptance, feed the held ADDI in PEND2.
  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    pend_d       = pend_q;
    err_valid_d  = 1'b0;
    err_code_d   = 2'd0;
    if (inst_valid_q && bus.i_inst_ready) begin
      inst_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (enc_err) begin
            err_valid_d = 1'b1;
            err_code_d  = enc_code;
          end else begin
            inst_d       = enc_w0;
            inst_valid_d = 1'b1;
            if (enc_two) begin
              pend_d  = enc_w1;
              state_d = PEND2;
            end
          end
        end
      end
      PEND2: begin
        if (out_free) begin
          inst_d       = pend_q;
          inst_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any pending second LI word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      inst_q       <= 32'd0;
      pend_q       <= 32'd0;
      inst_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      pend_q       <= pend_d;
      inst_valid_q <= inst_valid_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
    end
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_inst       = inst_q;
  assign bus.o_inst_valid = inst_valid_q;
  assign bus.o_err_valid  = err_valid_q;
  assign bus.o_err_code   = err_code_q;

endmodule

// File: tb/tb_asrv32_encoder.sv
// tb/tb_asrv32_encoder.sv - scoreboard bench for asrv32_encoder
module tb_asrv32_encoder;

  logic i_clk;
  logic i_rst_n;
  asrv32_encoder_if bus ();

  asrv32_encoder dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;

  bit [31:0] exp_inst[$];
  bit [1:0]  exp_err[$];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic bit fits(input bit [31:0] v, input int bits);
    longint s;
    longint lim;
    s   = longint'($signed(v));
    lim = longint'(1) << (bits - 1);
    return (s >= -lim) && (s < lim);
  endfunction

  function automatic void model(input bit [3:0] k, input bit [2:0] f3, input bit alt,
                                input bit [4:0] rs1_i, input bit [4:0] rs2_i, input bit [4:0] rd_i,
                                input bit [31:0] imm, output bit err, output bit [1:0] code,
                                output int n, output bit [31:0] w0, output bit [31:0] w1);
    bit [31:0] r1, r2, d, f, a, hi;
    r1 = 32'(rs1_i); r2 = 32'(rs2_i); d = 32'(rd_i); f = 32'(f3); a = 32'(alt);
    err = 0; code = 0; n = 1; w0 = 0; w1 = 0;
    case (k)
      0: if (alt && f3 != 0 && f3 != 5) begin err = 1; code = 3; end
         else w0 = (a << 30) | (r2 << 20) | (r1 << 15) | (f << 12) | (d << 7) | 32'h33;
      1: if (f3 == 1 || f3 == 5) begin
           if ((imm >> 5) != 0 || (f3 == 1 && alt)) begin err = 1; code = 3; end
           else w0 = ((f3 == 5 && alt) ? 32'h4000_0000 : 0) | (imm << 20) | (r1 << 15) | (f << 12) | (d << 7) | 32'h13;
         end else if (!fits(imm, 12)) begin err = 1; code = 1; end
         else w0 = ((imm & 32'hFFF) << 20) | (r1 << 15) | (f << 12) | (d << 7) | 32'h13;
      2, 6: if (!fits(imm, 12)) begin err = 1; code = 1; end
         else w0 = ((imm & 32'hFFF) << 20) | (r1 << 15) | (f << 12) | (d << 7) | (k == 2 ? 32'h03 : 32'h67);
      3: if (!fits(imm, 12)) begin err = 1; code = 1; end
         else w0 = (((imm >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f << 12) | ((imm & 32'h1F) << 7) | 32'h23;
      4: if (imm[0]) begin err = 1; code = 2; end
         else if (!fits(imm, 13)) begin err = 1; code = 1; end
         else w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (r2 << 20) | (r1 << 15) |
                   (f << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
      5: if (imm[0]) begin err = 1; code = 2; end
         else if (!fits(imm, 21)) begin err = 1; code = 1; end
         else w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20) |
                   (((imm >> 12) & 32'hFF) << 12) | (d << 7) | 32'h6F;
      7, 8: if ((imm & 32'hFFF) != 0) begin err = 1; code = 1; end
         else w0 = (imm & 32'hFFFFF000) | (d << 7) | (k == 7 ? 32'h37 : 32'h17);
      9, 10: if ((imm >> 12) != 0) begin err = 1; code = 1; end
         else w0 = (imm << 20) | (r1 << 15) | (f << 12) | (d << 7) | (k == 9 ? 32'h73 : 32'h0F);
      11: if (fits(imm, 12)) w0 = ((imm & 32'hFFF) << 20) | (d << 7) | 32'h13;
         else if ((imm & 32'hFFF) == 0) w0 = imm | (d << 7) | 32'h37;
         else begin
           hi = imm + 32'h800;
           n  = 2;
           w0 = (hi & 32'hFFFFF000) | (d << 7) | 32'h37;
           w1 = ((imm & 32'hFFF) << 20) | (d << 15) | (d << 7) | 32'h13;
         end
      default: begin err = 1; code = 0; end
    endcase
    if (err) n = 0;
  endfunction

  task automatic req(input bit [3:0] k, input bit [2:0] f3, input bit alt, input bit [4:0] rs1_i,
                     input bit [4:0] rs2_i, input bit [4:0] rd_i, input bit [31:0] imm, output int waits);
    bit done;
    bus.i_kind = k; bus.i_funct3 = f3; bus.i_alt = alt;
    bus.i_rs1 = rs1_i; bus.i_rs2 = rs2_i; bus.i_rd = rd_i; bus.i_imm = imm;
    bus.i_req_valid = 1'b1;
    waits = 0;
    done = 0;
    while (!done && waits < 200) begin
      @(negedge i_clk);
      if (bus.o_req_ready) done = 1;
      else waits++;
    end
    if (!done) chk("req_accept_timeout", 64'd0, 64'd1);
    @(posedge i_clk);
    #1;
    bus.i_req_valid = 1'b0;
  endtask

  task automatic req_model(input bit [3:0] k, input bit [2:0] f3, input bit alt, input bit [4:0] rs1_i,
                           input bit [4:0] rs2_i, input bit [4:0] rd_i, input bit [31:0] imm);
    bit e; bit [1:0] c; int n; bit [31:0] w0, w1; int w;
    model(k, f3, alt, rs1_i, rs2_i, rd_i, imm, e, c, n, w0, w1);
    if (e) exp_err.push_back(c);
    if (n >= 1) exp_inst.push_back(w0);
    if (n == 2) exp_inst.push_back(w1);
    req(k, f3, alt, rs1_i, rs2_i, rd_i, imm, w);
  endtask

  // Monitor: pops expectations on every consumed word and every error pulse.
  bit        stall_prev = 0;
  bit [31:0] prev_inst  = 0;
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n && bus.o_err_valid) begin
        if (exp_err.size() == 0) chk("err_unexpected", {62'd0, bus.o_err_code}, 64'hFFFF);
        else chk("err_code", {62'd0, bus.o_err_code}, {62'd0, exp_err.pop_front()});
      end
      if (i_rst_n && bus.o_inst_valid && bus.i_inst_ready) begin
        if (exp_inst.size() == 0) chk("inst_unexpected", {32'd0, bus.o_inst}, 64'hFFFF_FFFF_FFFF);
        else chk("inst_word", {32'd0, bus.o_inst}, {32'd0, exp_inst.pop_front()});
      end
      if (stall_prev && i_rst_n) chk("inst_hold", {31'd0, bus.o_inst_valid, bus.o_inst}, {31'd0, 1'b1, prev_inst});
      stall_prev = i_rst_n && bus.o_inst_valid && !bus.i_inst_ready;
      prev_inst  = bus.o_inst;
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (rdy_mode == 1) bus.i_inst_ready = ($urandom % 4) != 0;
    end
  end

  initial begin
    int w;
    bit [3:0] k; bit [2:0] f3; bit alt; bit [31:0] imm;
    i_rst_n = 1'b0;
    bus.i_req_valid = 0; bus.i_kind = 0; bus.i_funct3 = 0; bus.i_alt = 0;
    bus.i_rs1 = 0; bus.i_rs2 = 0; bus.i_rd = 0; bus.i_imm = 0; bus.i_inst_ready = 1;

    // Reset state
    @(posedge i_clk); @(negedge i_clk);
    chk("rst_inst_valid", {63'd0, bus.o_inst_valid}, 64'd0);
    chk("rst_inst", {32'd0, bus.o_inst}, 64'd0);
    chk("rst_err_valid", {63'd0, bus.o_err_valid}, 64'd0);
    chk("rst_err_code", {62'd0, bus.o_err_code}, 64'd0);
    chk("rst_req_ready", {63'd0, bus.o_req_ready}, 64'd0);
    @(posedge i_clk); #1; i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_ready", {63'd0, bus.o_req_ready}, 64'd1);
    @(posedge i_clk); #1;

    // RTYPE add / sub
    exp_inst.push_back(32'h002081B3);
    req(0, 0, 0, 1, 2, 3, 0, w);
    @(negedge i_clk);
    chk("rtype_add", {31'd0, bus.o_inst_valid, bus.o_inst}, {31'd0, 1'b1, 32'h002081B3});
    @(posedge i_clk); #1;
    exp_inst.push_back(32'h402081B3);
    req(0, 0, 1, 1, 2, 3, 0, w);
    @(negedge i_clk);
    chk("rtype_sub", {32'd0, bus.o_inst}, {32'd0, 32'h402081B3});
    @(posedge i_clk); #1;

    // LI two-word expansion, back-to-back
    exp_inst.push_back(32'h123462B7);
    exp_inst.push_back(32'hFFF28293);
    req(11, 0, 0, 0, 0, 5, 32'h12345FFF, w);
    @(negedge i_clk);
    chk("li_lui", {31'd0, bus.o_inst_valid, bus.o_inst}, {31'd0, 1'b1, 32'h123462B7});
    chk("li_pend_ready", {63'd0, bus.o_req_ready}, 64'd0);
    @(negedge i_clk);
    chk("li_addi", {31'd0, bus.o_inst_valid, bus.o_inst}, {31'd0, 1'b1, 32'hFFF28293});
    @(posedge i_clk); #1;

    // Branch encode and misaligned error
    exp_inst.push_back(32'hFE208EE3);
    req(4, 0, 0, 1, 2, 0, 32'hFFFFFFFC, w);
    exp_err.push_back(2'd2);
    req(4, 0, 0, 1, 2, 0, 32'd3, w);
    @(negedge i_clk);
    chk("br_err", {61'd0, bus.o_err_valid, bus.o_err_code}, {61'd0, 1'b1, 2'd2});
    chk("br_err_noinst", {63'd0, bus.o_inst_valid}, 64'd0);
    @(negedge i_clk);
    chk("br_err_pulse", {63'd0, bus.o_err_valid}, 64'd0);
    @(posedge i_clk); #1;

    // Shift-amount error and bad kind
    exp_err.push_back(2'd3);
    req(1, 3'b001, 0, 1, 0, 2, 32'd32, w);
    @(negedge i_clk);
    chk("shamt_err", {61'd0, bus.o_err_valid, bus.o_err_code}, {61'd0, 1'b1, 2'd3});
    @(negedge i_clk);
    chk("shamt_pulse", {63'd0, bus.o_err_valid}, 64'd0);
    @(posedge i_clk); #1;
    exp_err.push_back(2'd0);
    req(13, 0, 0, 0, 0, 0, 0, w);
    @(negedge i_clk);
    chk("kind_err", {61'd0, bus.o_err_valid, bus.o_err_code}, {61'd0, 1'b1, 2'd0});
    @(negedge i_clk);
    chk("kind_pulse", {63'd0, bus.o_err_valid}, 64'd0);
    @(posedge i_clk); #1;

    // Backpressure hold, then accept on the release edge
    bus.i_inst_ready = 0;
    exp_inst.push_back(32'h002081B3);
    req(0, 0, 0, 1, 2, 3, 0, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("stall_out", {30'd0, bus.o_inst_valid, bus.o_req_ready, bus.o_inst}, {30'd0, 1'b1, 1'b0, 32'h002081B3});
    end
    @(posedge i_clk); #1;
    bus.i_inst_ready = 1;
    exp_inst.push_back(32'h402081B3);
    req(0, 0, 1, 1, 2, 3, 0, w);
    chk("release_same_edge", 64'(w), 64'd0);
    @(negedge i_clk);
    @(posedge i_clk); #1;

    // Reset during PEND2 discards the ADDI word
    req(11, 0, 0, 0, 0, 5, 32'h12345FFF, w);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("rst_pend_lui", {32'd0, bus.o_inst}, {32'd0, 32'h123462B7});
    chk("rst_pend_ready", {63'd0, bus.o_req_ready}, 64'd0);
    @(negedge i_clk);
    chk("rst_pend_clear", {63'd0, bus.o_inst_valid}, 64'd0);
    @(posedge i_clk); #1; i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("no_addi_after_rst", {63'd0, bus.o_inst_valid}, 64'd0);
    end
    @(posedge i_clk); #1;

    // Randomized traffic against the reference model
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      k   = 4'($urandom_range(0, 15));
      f3  = 3'($urandom);
      alt = ($urandom % 4) == 0;
      case ($urandom % 7)
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = (32'($urandom_range(0, 16383)) - 32'd8192) & 32'hFFFF_FFFE;
        3: imm = 32'($urandom_range(0, 40));
        4: imm = $urandom & 32'hFFFFF000;
        5: imm = $urandom & 32'h00000FFF;
        default: imm = (32'($urandom_range(0, 4194303)) - 32'd2097152) & 32'hFFFF_FFFE;
      endcase
      req_model(k, f3, alt, 5'($urandom), 5'($urandom), 5'($urandom), imm);
      repeat ($urandom_range(0, 2)) @(posedge i_clk);
      #1;
    end

    // Drain
    rdy_mode = 0;
    bus.i_inst_ready = 1;
    for (int i = 0; i < 500 && (exp_inst.size() != 0 || exp_err.size() != 0); i++) @(posedge i_clk);
    repeat (3) @(posedge i_clk);
    chk("drain_inst", 64'(exp_inst.size()), 64'd0);
    chk("drain_err", 64'(exp_err.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asrv32_encoder.md
ASRV32_ENCODER -- requirements
Module: asrv32_encoder

Interface
REQ-001 SHALL have no parameters.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_req_valid  in  1  encode request present.
REQ-005 o_req_ready  out  1  request accepted when i_req_valid && o_req_ready at a rising edge.
REQ-006 i_kind  in  4  0 RTYPE, 1 ITYPE, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 10 FENCE, 11 LI (load-immediate macro), 12-15 illegal.
REQ-007 i_funct3  in  3  funct3 field; i_alt  in  1  inst[30] selector (SUB/SRA/SRAI).
REQ-008 i_rs1, i_rs2, i_rd  in  5 each  register addresses.
REQ-009 i_imm  in  32  byte-offset/value immediate, two's complement.
REQ-010 o_inst  out  32  encoded RV32I instruction; o_inst_valid  out  1; i_inst_ready  in  1  consumer accepts o_inst.
REQ-011 o_err_valid  out  1  one-cycle error pulse; o_err_code  out  2  0 bad kind, 1 imm range, 2 misaligned, 3 bad shift.

Function
REQ-012 Field placement SHALL be inverse of asrv32_decoder: rs1[19:15], rs2[24:20], rd[11:7], funct3[14:12], opcode[6:0].
REQ-013 RTYPE: inst[31:25] = {1'b0, i_alt, 5'b0}; i_alt honoured only for funct3 000/101, else error code 3.
REQ-014 ITYPE/LOAD/JALR: imm[11:0] in [31:20]; i_imm SHALL fit signed 12-bit (i_imm[31:11] all equal) else code 1.
REQ-015 ITYPE funct3 001/101: i_imm[31:5] SHALL be 0 else code 3; inst[30]=i_alt for 101; i_alt=1 with 001 is code 3.
REQ-016 STORE: signed 12-bit range as REQ-014; split [31:25]/[11:7].
REQ-017 BRANCH: signed 13-bit range (code 1), i_imm[0]=0 (code 2), B-format scatter.
REQ-018 JAL: signed 21-bit range (code 1), i_imm[0]=0 (code 2), J-format scatter; funct3 ignored.
REQ-019 LUI/AUIPC: i_imm[11:0] SHALL be 0 else code 1; inst[31:12]=i_imm[31:12].
REQ-020 SYSTEM/FENCE: i_imm[31:12] SHALL be 0 else code 1; i_imm[11:0] in [31:20].
REQ-021 Range check precedence: kind, then shift, then misaligned, then range.
REQ-022 LI: if i_imm fits signed 12-bit -> one ADDI rd,x0,imm; else if i_imm[11:0]=0 -> one LUI; else LUI rd,hi then ADDI rd,rd,lo, hi=(i_imm+32'h800)[31:12] mod 2^32, lo=i_imm[11:0].
REQ-023 FSM states IDLE, PEND2; two-word LI enters PEND2 holding ADDI word; PEND2 -> IDLE when ADDI loaded into output register.
REQ-024 Single output register; accepted request loads it at edge N, o_inst_valid=1 from N+1 (latency 1).
REQ-025 o_req_ready = (state==IDLE) && (!o_inst_valid || i_inst_ready).
REQ-026 While o_inst_valid && !i_inst_ready, o_inst SHALL hold stable.
REQ-027 In PEND2, ADDI word SHALL load on the edge the LUI word is consumed; back-to-back, no bubble.
REQ-028 Output consumed with no new load clears o_inst_valid.
REQ-029 Errored request: accepted, nothing loaded, o_err_valid=1 for exactly the cycle after acceptance with code; output register untouched.
REQ-030 Unused fields per kind SHALL be encoded as 0 (e.g. rs2 for ITYPE).

Reset
REQ-031 While i_rst_n=0 at an edge: state IDLE, o_inst_valid=0, o_inst=0, o_err_valid=0, o_err_code=0; pending LI second word discarded.
REQ-032 o_req_ready SHALL be 0 during reset cycle, valid by first cycle after release.

Verification
REQ-033 RTYPE funct3=0 rs1=1 rs2=2 rd=3 i_alt=0 -> o_inst=0x002081B3 one cycle later; i_alt=1 -> 0x402081B3.
REQ-034 LI rd=5 i_imm=0x12345FFF, ready=1 -> 0x123462B7 then 0xFFF28293 consecutive cycles; o_req_ready=0 during PEND2.
REQ-035 BRANCH funct3=0 rs1=1 rs2=2 i_imm=-4 -> 0xFE208EE3; i_imm=3 -> no o_inst_valid, o_err_code=2 pulse.
REQ-036 ITYPE funct3=001 i_imm=32 -> o_err_code=3; i_kind=13 -> o_err_code=0; both single-cycle pulses.
REQ-037 Hold i_inst_ready=0 three cycles with valid output -> o_inst stable, o_req_ready=0; release -> next request accepted same edge.
REQ-038 Assert i_rst_n=0 during PEND2 -> o_inst_valid=0 next cycle; ADDI word never emitted.
